// File: rtl/iter_divider_if.sv
// Handshake and operand bundle for the iterative divider.
// Requester drives the master side; the divider implements the slave side.
interface iter_divider_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic             signed_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic [WIDTH-1:0] quotient_o;
  logic [WIDTH-1:0] remainder_o;
  logic             busy_o;
  logic             done_o;
  logic             DivZero_o;

  modport master (
    output start_i, signed_i, data1_i, data2_i,
    input  quotient_o, remainder_o, busy_o, done_o, DivZero_o
  );

  modport slave (
    input  start_i, signed_i, data1_i, data2_i,
    output quotient_o, remainder_o, busy_o, done_o, DivZero_o
  );
endinterface

// File: rtl/iter_divider.sv
// Iterative restoring divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Define DIV_EARLY_OUT_EN to finish div-by-zero, overflow and |a|<|b| in one step.
module iter_divider #(
  parameter int WIDTH = 32
) (
  input logic          clk_i,
  input logic          rst_i,
  iter_divider_if.slave div_if
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE, CALC, FIX, DONE
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] rem_q, dvd_q, dsr_q, orig_q;
  logic [WIDTH-1:0] quo_q, rmd_q;
  logic [CW-1:0]    cnt_q;
  logic             negq_q, negr_q, dz_q, ovf_q;
  logic             busy_q, done_q, divz_q;

  logic [WIDTH-1:0] a, b, a_mag, b_mag;
  logic             a_neg, b_neg, dz, ovf, early;
  logic [WIDTH:0]   shl_d, trial_d;
  logic [WIDTH-1:0] qfix_d, rfix_d;

  always_comb begin
    a     = div_if.data1_i;
    b     = div_if.data2_i;
    a_neg = div_if.signed_i & a[WIDTH-1];
    b_neg = div_if.signed_i & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
    dz    = (b == '0);
    ovf   = div_if.signed_i
          & (a == {1'b1, {(WIDTH-1){1'b0}}})
          & (b == '1);
  end

`ifdef DIV_EARLY_OUT_EN
  logic [WIDTH-1:0] eq_d, er_d;
  always_comb begin
    early = dz | ovf | (a_mag < b_mag);
    eq_d  = '0;
    er_d  = a;
    if (dz) begin
      eq_d = '1;
    end else if (ovf) begin
      eq_d = a;
      er_d = '0;
    end
  end
`else
  assign early = 1'b0;
`endif

  // Trial subtract needs the bit shifted out of rem, hence WIDTH+1 bits.
  always_comb begin
    shl_d   = {rem_q, dvd_q[WIDTH-1]};
    trial_d = shl_d - {1'b0, dsr_q};
    qfix_d  = negq_q ? -dvd_q : dvd_q;
    rfix_d  = negr_q ? -rem_q : rem_q;
    if (dz_q) begin
      qfix_d = '1;
      rfix_d = orig_q;
    end else if (ovf_q) begin
      qfix_d = orig_q;
      rfix_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rem_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      orig_q  <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      divz_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (div_if.start_i && !done_q) begin
            divz_q <= 1'b0;
            if (early) begin
`ifdef DIV_EARLY_OUT_EN
              quo_q  <= eq_d;
              rmd_q  <= er_d;
              divz_q <= dz;
`endif
              state_q <= DONE;
            end else begin
              rem_q   <= '0;
              dvd_q   <= a_mag;
              dsr_q   <= b_mag;
              orig_q  <= a;
              negq_q  <= a_neg ^ b_neg;
              negr_q  <= a_neg;
              dz_q    <= dz;
              ovf_q   <= ovf;
              cnt_q   <= CW'(WIDTH - 1);
              busy_q  <= 1'b1;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= trial_d[WIDTH] ? shl_d[WIDTH-1:0]
                                  : trial_d[WIDTH-1:0];
          dvd_q <= {dvd_q[WIDTH-2:0], ~trial_d[WIDTH]};
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) state_q <= FIX;
        end
        FIX: begin
          quo_q   <= qfix_d;
          rmd_q   <= rfix_d;
          divz_q  <= dz_q;
          busy_q  <= 1'b0;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign div_if.quotient_o  = quo_q;
  assign div_if.remainder_o = rmd_q;
  assign div_if.busy_o      = busy_q;
  assign div_if.done_o      = done_q;
  assign div_if.DivZero_o   = divz_q;
endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider; expected latencies follow DIV_EARLY_OUT_EN.
// Outputs sampled 1ns after the rising edge, inputs driven on the falling edge.
module tb_iter_divider;
  localparam int W = 32;
  localparam int FULL = 34;
`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY = 1;
`else
  localparam int EARLY = FULL;
`endif

  logic clk;
  logic rst;
  int   total;
  int   bad;

  iter_divider_if #(.WIDTH(W)) dif ();

  iter_divider #(.WIDTH(W)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .div_if (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Issue one op; lat = edges after the start edge until done_o seen.
  task automatic op(input logic s,
                    input logic [31:0] a,
                    input logic [31:0] b,
                    output int lat,
                    output int busyc,
                    output int after);
    @(negedge clk);
    dif.signed_i = s;
    dif.data1_i  = a;
    dif.data2_i  = b;
    dif.start_i  = 1'b1;
    @(posedge clk);
    #1;
    dif.start_i = 1'b0;
    busyc = dif.busy_o ? 1 : 0;
    lat   = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (dif.done_o) begin
        lat = k;
        break;
      end
      if (dif.busy_o) busyc++;
    end
    @(posedge clk);
    #1;
    after = dif.done_o ? 1 : 0;
  endtask

  int lat, busyc, after, dones;

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    dif.start_i  = 1'b0;
    dif.signed_i = 1'b0;
    dif.data1_i  = '0;
    dif.data2_i  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_quo",  dif.quotient_o, 32'h0);
    chk("rst_rem",  dif.remainder_o, 32'h0);
    chk("rst_busy", {31'b0, dif.busy_o}, 32'h0);
    chk("rst_done", {31'b0, dif.done_o}, 32'h0);
    chk("rst_dz",   {31'b0, dif.DivZero_o}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    op(1'b1, 32'd100, 32'd7, lat, busyc, after);
    chk("s100_7_q",    dif.quotient_o, 32'd14);
    chk("s100_7_r",    dif.remainder_o, 32'd2);
    chk("s100_7_dz",   {31'b0, dif.DivZero_o}, 32'h0);
    chk("s100_7_lat",  lat, FULL);
    chk("s100_7_busy", busyc, 33);
    chk("s100_7_pulse", after, 0);

    op(1'b1, 32'hFFFF_FF9C, 32'd7, lat, busyc, after);
    chk("sm100_7_q", dif.quotient_o, 32'hFFFF_FFF2);
    chk("sm100_7_r", dif.remainder_o, 32'hFFFF_FFFE);

    op(1'b0, 32'hFFFF_FFFF, 32'd2, lat, busyc, after);
    chk("u_max_2_q", dif.quotient_o, 32'h7FFF_FFFF);
    chk("u_max_2_r", dif.remainder_o, 32'd1);

    op(1'b1, 32'd7, 32'd0, lat, busyc, after);
    chk("s7_0_q",   dif.quotient_o, 32'hFFFF_FFFF);
    chk("s7_0_r",   dif.remainder_o, 32'd7);
    chk("s7_0_dz",  {31'b0, dif.DivZero_o}, 32'h1);
    chk("s7_0_lat", lat, EARLY);

    op(1'b0, 32'd7, 32'd0, lat, busyc, after);
    chk("u7_0_q",   dif.quotient_o, 32'hFFFF_FFFF);
    chk("u7_0_r",   dif.remainder_o, 32'd7);
    chk("u7_0_dz",  {31'b0, dif.DivZero_o}, 32'h1);
    chk("u7_0_lat", lat, EARLY);

    op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, busyc, after);
    chk("ovf_q",   dif.quotient_o, 32'h8000_0000);
    chk("ovf_r",   dif.remainder_o, 32'h0);
    chk("ovf_dz",  {31'b0, dif.DivZero_o}, 32'h0);
    chk("ovf_lat", lat, EARLY);

    op(1'b0, 32'd3, 32'd10, lat, busyc, after);
    chk("u3_10_q",   dif.quotient_o, 32'h0);
    chk("u3_10_r",   dif.remainder_o, 32'd3);
    chk("u3_10_lat", lat, EARLY);

    // A second start mid-operation must be dropped.
    @(negedge clk);
    dif.signed_i = 1'b1;
    dif.data1_i  = 32'd100;
    dif.data2_i  = 32'd7;
    dif.start_i  = 1'b1;
    @(negedge clk);
    dif.start_i = 1'b0;
    repeat (4) @(negedge clk);
    dif.data1_i = 32'd1000;
    dif.data2_i = 32'd3;
    dif.start_i = 1'b1;
    @(negedge clk);
    dif.start_i = 1'b0;
    dones = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      #1;
      if (dif.done_o) dones++;
    end
    chk("ign_q",     dif.quotient_o, 32'd14);
    chk("ign_r",     dif.remainder_o, 32'd2);
    chk("ign_dones", dones, 1);

    // Reset ten cycles into an op aborts it.
    @(negedge clk);
    dif.signed_i = 1'b0;
    dif.data1_i  = 32'd1000;
    dif.data2_i  = 32'd3;
    dif.start_i  = 1'b1;
    @(negedge clk);
    dif.start_i = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("ab_quo",  dif.quotient_o, 32'h0);
    chk("ab_rem",  dif.remainder_o, 32'h0);
    chk("ab_busy", {31'b0, dif.busy_o}, 32'h0);
    chk("ab_done", {31'b0, dif.done_o}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (dif.done_o || dif.busy_o) dones++;
    end
    chk("ab_quiet", dones, 0);

    op(1'b1, 32'hFFFF_FF9C, 32'd7, lat, busyc, after);
    chk("post_q",   dif.quotient_o, 32'hFFFF_FFF2);
    chk("post_r",   dif.remainder_o, 32'hFFFF_FFFE);
    chk("post_lat", lat, FULL);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
